// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among NREQ byte requesters.
// Round-robin grant with packet lock, tx_en/busy_tx sequencing and an
// inter-frame gap. Optional LAUNCH/WAIT_DONE watchdog: UART_ARB_TIMEOUT_EN.
// Ports:
//   fpga_clk, nrst          clock, async active-low reset
//   req_valid/data/last     per-requester byte offer (data at [8i+7:8i])
//   req_ready               one-hot accept pulse
//   din, tx_en, busy_tx     uart_tx interface
//   grant_id, arb_busy      current owner, non-idle flag
//   timeout_err             one-cycle watchdog pulse (0 when disabled)
module uart_tx_arbiter #(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    fpga_clk,
    input  logic                    nrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              din,
    output logic                    tx_en,
    input  logic                    busy_tx,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    arb_busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_id;
    logic          locked;
    logic [GW-1:0] gap_cnt;

    logic          found;
    logic [IW-1:0] win_id;
    int            idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    logic unused_tmo;

    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    // Winner search. Scanning k from high to low lets the closest
    // requester after rr_ptr overwrite any farther one.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        if (locked) begin
            found  = req_valid[lock_id];
            win_id = lock_id;
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (req_valid[IW'(idx)]) begin
                    found  = 1'b1;
                    win_id = IW'(idx);
                end
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            rr_ptr    <= IW'(NREQ - 1);
            lock_id   <= '0;
            locked    <= 1'b0;
            gap_cnt   <= '0;
            req_ready <= '0;
            din       <= '0;
            tx_en     <= 1'b0;
            grant_id  <= '0;
            arb_busy  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (found) begin
                        req_ready <= NREQ'(1) << win_id;
                        din       <= req_data[{win_id, 3'b000} +: 8];
                        grant_id  <= win_id;
                        rr_ptr    <= win_id;
                        lock_id   <= win_id;
                        locked    <= ~req_last[win_id];
                        tx_en     <= 1'b1;
                        arb_busy  <= 1'b1;
                        state     <= S_LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                S_LAUNCH: begin
                    // A busy_tx already high here counts as the acknowledge.
                    if (busy_tx) begin
                        tx_en <= 1'b0;
                        state <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        tx_en       <= 1'b0;
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (!busy_tx) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        tx_en       <= 1'b0;
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                S_GAP: begin
                    // A zero gap still spends this one cycle in GAP.
                    if (GAP_CYCLES == 0 || gap_cnt == GAP_LAST) begin
                        arb_busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// NREQ=4, GAP_CYCLES=2, TIMEOUT_CYCLES=16.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  din;
    logic        tx_en;
    logic        busy_tx = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .fpga_clk(clk),
        .nrst(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .din(din),
        .tx_en(tx_en),
        .busy_tx(busy_tx),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        busy_tx   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Plays one uart_tx frame and reports what the arbiter launched.
    task automatic frame(output logic [7:0] d, output logic [1:0] g,
                         output logic [3:0] r, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        @(negedge clk);
        while (!tx_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_en) ok = 1'b0;
        d = din;
        g = grant_id;
        r = req_ready;
        @(posedge clk);
        #1;
        busy_tx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        busy_tx = 1'b0;
        n = 0;
        @(negedge clk);
        while (arb_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (arb_busy) ok = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({req_ready, din, tx_en, grant_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h/%h/%b/%0d want 0",
                     req_ready, din, tx_en, grant_id);
        end
        n_checks++;
        if ({arb_busy, timeout_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b%b want 00",
                     arb_busy, timeout_err);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req_data[7:0] = 8'hA5;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        n_checks++;
        if (din !== 8'hA5 || tx_en !== 1'b1) begin
            n_fail++;
            $display("FAIL single_launch: din %h tx_en %b want a5 1",
                     din, tx_en);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_ready_pulse: got %b want 0000", req_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b1) begin
            n_fail++;
            $display("FAIL single_tx_hold: got %b want 1", tx_en);
        end
        @(posedge clk);
        #1;
        busy_tx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_en !== 1'b0 || arb_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_tx_drop: tx_en %b arb_busy %b want 0 1",
                     tx_en, arb_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        busy_tx = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (arb_busy && n < 20);
        n_checks++;
        if (n != GAP + 1) begin
            n_fail++;
            $display("FAIL single_gap: idle after %0d cycles want %0d",
                     n, GAP + 1);
        end
        n_checks++;
        if (din !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_din_hold: got %h want a5", din);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] d;
        logic [1:0] g;
        logic [3:0] r;
        logic [7:0] exp_d [4];
        bit ok;
        exp_d[0] = 8'h10;
        exp_d[1] = 8'h21;
        exp_d[2] = 8'h32;
        exp_d[3] = 8'h43;
        do_reset();
        req_data  = 32'h43322110;
        req_last  = 4'hF;
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            frame(d, g, r, ok);
            n_checks++;
            if (!ok || g !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %0d ok %b want %0d",
                         i, g, ok, i % 4);
            end
            n_checks++;
            if (d !== exp_d[i % 4]) begin
                n_fail++;
                $display("FAIL rr_din[%0d]: got %h want %h",
                         i, d, exp_d[i % 4]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_packet_lock();
        logic [7:0] d;
        logic [1:0] g;
        logic [3:0] r;
        bit ok;
        bit bad;
        do_reset();
        req_data[23:16] = 8'h01;
        req_valid = 4'b0100;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd2 || d !== 8'h01) begin
            n_fail++;
            $display("FAIL lock_b0: got id %0d din %h want 2 01", g, d);
        end
        req_data[15:8] = 8'h55;
        req_last[1]    = 1'b1;
        req_valid      = 4'b0010;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (arb_busy || req_ready != 4'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL lock_stall: got activity want none");
        end
        req_data[23:16] = 8'h02;
        req_valid = 4'b0110;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd2 || d !== 8'h02) begin
            n_fail++;
            $display("FAIL lock_b1: got id %0d din %h want 2 02", g, d);
        end
        req_data[23:16] = 8'h03;
        req_last[2] = 1'b1;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || r !== 4'b0100 || d !== 8'h03) begin
            n_fail++;
            $display("FAIL lock_b2: got ready %b din %h want 0100 03", r, d);
        end
        req_data[31:24] = 8'h77;
        req_last[3] = 1'b1;
        req_valid = 4'b1010;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd3 || d !== 8'h77) begin
            n_fail++;
            $display("FAIL lock_after3: got id %0d din %h want 3 77", g, d);
        end
        req_valid = 4'b0010;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd1 || d !== 8'h55) begin
            n_fail++;
            $display("FAIL lock_after1: got id %0d din %h want 1 55", g, d);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic [1:0] g;
        logic [3:0] r;
        bit ok;
        int n;
        do_reset();
        req_data  = 32'h44332211;
        req_last  = 4'hF;
        req_valid = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        busy_tx   = 1'b1;
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (arb_busy !== 1'b1 || din !== 8'h11) begin
            n_fail++;
            $display("FAIL mid_pre: arb_busy %b din %h want 1 11",
                     arb_busy, din);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_en, req_ready, arb_busy, din} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: got %b/%b/%b/%h want 0",
                     tx_en, req_ready, arb_busy, din);
        end
        busy_tx = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        req_valid = 4'hF;
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd0 || d !== 8'h11) begin
            n_fail++;
            $display("FAIL mid_first: got id %0d din %h want 0 11", g, d);
        end
        req_valid = '0;
    endtask

    task automatic test_stale_busy();
        int n;
        int cnt;
        do_reset();
        busy_tx        = 1'b1;
        req_data[15:8] = 8'h99;
        req_last       = 4'hF;
        req_valid      = 4'b0010;
        n = 0;
        @(negedge clk);
        while (!tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        cnt = 0;
        while (tx_en && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL stale_tx_len: got %0d cycles want 1", cnt);
        end
        n_checks++;
        if (arb_busy !== 1'b1 || din !== 8'h99) begin
            n_fail++;
            $display("FAIL stale_wait: arb_busy %b din %h want 1 99",
                     arb_busy, din);
        end
        @(posedge clk);
        #1;
        busy_tx = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (arb_busy && n < 20);
        n_checks++;
        if (n != GAP + 1) begin
            n_fail++;
            $display("FAIL stale_gap: idle after %0d want %0d", n, GAP + 1);
        end
    endtask

    task automatic test_timeout();
        int n;
`ifdef UART_ARB_TIMEOUT_EN
        logic [7:0] d;
        logic [1:0] g;
        logic [3:0] r;
        bit ok;
        do_reset();
        req_data[7:0]  = 8'hE1;
        req_data[15:8] = 8'hE2;
        req_last       = 4'b0010;
        req_valid      = 4'b0011;
        n = 0;
        @(negedge clk);
        while (!tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 40);
        n_checks++;
        if (n != TMO || tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse: at %0d tx_en %b want %0d 0",
                     n, tx_en, TMO);
        end
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_width: got %b want 0", timeout_err);
        end
        frame(d, g, r, ok);
        n_checks++;
        if (!ok || g !== 2'd1 || d !== 8'hE2) begin
            n_fail++;
            $display("FAIL tmo_unlock: got id %0d din %h want 1 e2", g, d);
        end
        req_valid = '0;
`else
        bit bad;
        do_reset();
        req_data[7:0] = 8'hE1;
        req_last      = 4'hF;
        req_valid     = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!tx_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (timeout_err || !tx_en) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL no_tmo_wait: got drop/pulse want tx_en held");
        end
        @(posedge clk);
        #1;
        busy_tx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        busy_tx = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (arb_busy && n < 20);
        n_checks++;
        if (arb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_tmo_idle: arb_busy %b want 0", arb_busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_reset_mid_frame();
        test_stale_busy();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among NREQ byte requesters using round-robin arbitration with packet lock.
- Accepts bytes over per-requester valid/ready handshakes.
- Sequences the transmitter: drives din and tx_en, tracks busy_tx through each frame, and inserts a programmable inter-frame gap.
- Sits between the command/telemetry sources and uart_tx.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle fpga_clk cycles inserted after busy_tx falls, before the next grant (0 allowed).
- TIMEOUT_CYCLES, 4096, watchdog limit per wait state; used only with UART_ARB_TIMEOUT_EN.

Ports:
- fpga_clk  in  1  system clock, single clock domain.
- nrst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte.
- req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NREQ  byte is the last of its packet.
- req_ready  out  NREQ  one-hot accept pulse.
- din  out  8  byte to uart_tx.
- tx_en  out  1  transmit request to uart_tx.
- busy_tx  in  1  uart_tx frame in progress.
- grant_id  out  $clog2(NREQ)  requester owning the current/last byte.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle watchdog pulse.

Behaviour:
- Reset values (async, on nrst low, any state):
  - Outputs: req_ready=0, din=0, tx_en=0, grant_id=0, arb_busy=0, timeout_err=0.
  - Internal: state=IDLE, rr_ptr=NREQ-1, locked=0, gap_cnt=0.
  - Reset mid-frame abandons the byte; nothing is retried.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE, when unlocked:
  - Candidate search starts at (rr_ptr+1) mod NREQ, ascending with wrap. The first i with req_valid[i]=1 wins.
- IDLE, when locked:
  - Only lock_id is considered. Other requesters stall regardless of valid.
- On a win at cycle T:
  - req_ready[g]=1 for exactly cycle T. The transfer completes on valid&ready.
  - din<=req_data[g], grant_id<=g, rr_ptr<=g.
  - If req_last[g]=0: locked<=1, lock_id<=g. If req_last[g]=1: locked<=0.
  - tx_en=1 from cycle T+1. State goes to LAUNCH.
- Requesters must hold valid and data stable until ready. Dropping valid before ready is legal; that requester is then simply skipped.
- LAUNCH:
  - Hold tx_en=1 and din stable until busy_tx=1 is sampled.
  - Next cycle: tx_en=0, go to WAIT_DONE.
- WAIT_DONE:
  - Hold din stable. When busy_tx=0 is sampled, go to GAP with gap_cnt=0.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES=0 goes to IDLE on the next cycle.
  - busy_tx is ignored in GAP.
- busy_tx already 1 when entering LAUNCH (spurious or stale): treated as the acknowledge; proceed to WAIT_DONE next cycle.
- Simultaneous valid on all requesters: strict round-robin, each requester granted once per NREQ packets.
- rr_ptr wraps from NREQ-1 to 0.
- Locked packet with req_valid[lock_id]=0: remain in IDLE, locked. Lock persists with no timeout.
- Throughput: minimum per-byte cycles = 1 (IDLE) + LAUNCH + frame time + 1 + GAP_CYCLES.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to LAUNCH and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES in either state: tx_en<=0, timeout_err=1 for one cycle, locked<=0, go to GAP. The byte is dropped.
- Undefined:
  - No counter. LAUNCH and WAIT_DONE wait indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Single byte: req_valid[0]=1, req_data=0xA5, req_last=1. Expect req_ready[0] for one cycle, din=0xA5, tx_en next cycle held until busy_tx=1, then dropped. After busy_tx falls, arb_busy=0 after GAP_CYCLES+1 cycles.
- Round-robin: all four valid with last=1 continuously, bytes 0x10/0x21/0x32/0x43. Expect grant order 0,1,2,3,0 and din sequence matching.
- Packet lock: req 2 sends 0x01,0x02,0x03 (last on 0x03) while req 1 is valid. Expect all three req-2 bytes before any req_ready[1]; then grant_id=3 if valid, else 1 (search from 3).
- Reset mid-frame: assert nrst=0 in WAIT_DONE. Expect tx_en=0, req_ready=0, arb_busy=0 immediately (asynchronous). After release, requester 0 wins first.
- Stale busy_tx: busy_tx=1 at LAUNCH entry. Expect tx_en high for exactly one cycle, then WAIT_DONE.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: busy_tx stuck at 0. Expect timeout_err pulse 16 cycles after LAUNCH entry, tx_en=0, lock cleared, next requester granted after the gap.
